// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate formats, decoded control bundle.
// Latency: none (constants, types and pure functions only).
// Backpressure: not applicable.
package decode_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I_OP = 7'b0010011;
  localparam logic [6:0] OP_I_LD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Width-independent part of the decoded bundle; data fields scale with XLEN/PC_W.
  typedef struct packed {
    logic [6:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rd_write;
    logic       is_load;
    logic       is_branch;
    logic       illegal;
  } dec_ctrl_t;

  // Immediate layout selected by the major opcode.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    imm_fmt_e fmt;
    case (op)
      OP_I_OP, OP_I_LD: fmt = IMM_I;
      OP_S:             fmt = IMM_S;
      OP_B:             fmt = IMM_B;
      OP_J:             fmt = IMM_J;
      OP_LUI:           fmt = IMM_U;
      default:          fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: NREGS x XLEN, two combinational read ports, one synchronous write port.
// Latency: reads are combinational; a write is visible to reads the cycle after the edge.
// Backpressure: none; writes are accepted every cycle, x0 reads as zero and ignores writes.
module decode_stage_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic [$clog2(NREGS)-1:0] rs1_idx,
  input  logic [$clog2(NREGS)-1:0] rs2_idx,
  output logic [XLEN-1:0]          rs1_dat,
  output logic [XLEN-1:0]          rs2_dat,
  input  logic                     wr_vld,
  input  logic [$clog2(NREGS)-1:0] wr_idx,
  input  logic [XLEN-1:0]          wr_dat
);

  logic [XLEN-1:0] mem_q [NREGS];

  // Storage is deliberately not reset; x0 is never written.
  always_ff @(posedge clk) begin
    if (wr_vld && (wr_idx != '0)) begin
      mem_q[wr_idx] <= wr_dat;
    end
  end

  // Read ports with x0 hardwired to zero.
  always_comb begin
    rs1_dat = (rs1_idx == '0) ? '0 : mem_q[rs1_idx];
    rs2_dat = (rs2_idx == '0) ? '0 : mem_q[rs2_idx];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, register read, RAW scoreboard stall; DECODE_FWD_EN enables writeback bypass.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready drops on a full-and-stalled output, a RAW hazard, flush or reset; outputs hold while out_ready=0.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  input  logic                     wb_valid,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [6:0]               out_alu_op,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic                     out_rd_write,
  output logic [XLEN-1:0]          out_rs1_val,
  output logic [XLEN-1:0]          out_rs2_val,
  output logic [XLEN-1:0]          out_imm,
  output logic                     out_is_load,
  output logic                     out_is_branch,
  output logic                     out_illegal
);

  localparam int RW = $clog2(NREGS);

  logic [6:0]      opcode;
  logic [RW-1:0]   rs1, rs2, rd;
  logic            rs1_used, rs2_used;
  dec_ctrl_t       ctrl;
  logic [31:0]     imm_raw;
  logic [XLEN-1:0] imm_sx;
  logic [XLEN-1:0] rf_rs1, rf_rs2, rs1_val, rs2_val;
  logic            byp1, byp2, hazard, accept, kill;

  logic             out_valid_q, out_valid_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  dec_ctrl_t        out_ctrl_q, out_ctrl_d;
  logic [RW-1:0]    out_rd_q, out_rd_d;
  logic [XLEN-1:0]  out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d, out_imm_q, out_imm_d;
  logic [NREGS-1:0] pending_q, pending_d;

  decode_stage_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rs1_idx (rs1),
    .rs2_idx (rs2),
    .rs1_dat (rf_rs1),
    .rs2_dat (rf_rs2),
    .wr_vld  (wb_valid),
    .wr_idx  (wb_rd),
    .wr_dat  (wb_data)
  );

  // Field extraction, legality, register usage and immediate assembly.
  always_comb begin
    opcode = in_instr[6:0];
    rd     = RW'(in_instr[11:7]);
    rs1    = RW'(in_instr[19:15]);
    rs2    = RW'(in_instr[24:20]);

    ctrl           = '0;
    ctrl.alu_op    = opcode;
    ctrl.funct3    = in_instr[14:12];
    ctrl.funct7    = in_instr[31:25];
    ctrl.is_load   = (opcode == OP_I_LD);
    ctrl.is_branch = (opcode == OP_B) || (opcode == OP_J);
    ctrl.illegal   = 1'b1;
    rs1_used       = 1'b0;
    rs2_used       = 1'b0;
    case (opcode)
      OP_R:          begin ctrl.illegal = 1'b0; ctrl.rd_write = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_I_OP,
      OP_I_LD:       begin ctrl.illegal = 1'b0; ctrl.rd_write = 1'b1; rs1_used = 1'b1; end
      OP_S, OP_B:    begin ctrl.illegal = 1'b0; rs1_used = 1'b1; rs2_used = 1'b1; end
      OP_J, OP_LUI:  begin ctrl.illegal = 1'b0; ctrl.rd_write = 1'b1; end
      default:       ;
    endcase

    case (imm_fmt(opcode))
      IMM_I:   imm_raw = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm_raw = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm_raw = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U:   imm_raw = {in_instr[31:12], 12'b0};
      IMM_J:   imm_raw = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: imm_raw = '0;
    endcase
    imm_sx = XLEN'($signed(imm_raw));
  end

  // Operand selection and RAW hazard; a same-cycle writeback can satisfy a source only with bypass enabled.
  always_comb begin
`ifdef DECODE_FWD_EN
    byp1 = wb_valid && (wb_rd == rs1) && (rs1 != '0);
    byp2 = wb_valid && (wb_rd == rs2) && (rs2 != '0);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
    rs1_val = byp1 ? wb_data : rf_rs1;
    rs2_val = rs2_used ? (byp2 ? wb_data : rf_rs2) : '0;
    hazard  = (rs1_used && (rs1 != '0) && pending_q[rs1] && !byp1) ||
              (rs2_used && (rs2 != '0) && pending_q[rs2] && !byp2);
    // Reset also blocks accept so fetch never loses an instruction into a clearing register.
    in_ready = (!out_valid_q || out_ready) && !hazard && !flush && !reset;
    accept   = in_valid && in_ready;
    kill     = flush && out_valid_q && !out_ready;
  end

  // Next state for the output register and scoreboard; a new set beats a same-cycle clear.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_ctrl_d  = out_ctrl_q;
    out_rd_d    = out_rd_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_imm_d   = out_imm_q;
    pending_d   = pending_q;

    if (out_ready) out_valid_d = 1'b0;
    if (flush)     out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      out_pc_d    = in_pc;
      out_ctrl_d  = ctrl;
      out_rd_d    = rd;
      out_rs1_d   = rs1_val;
      out_rs2_d   = rs2_val;
      out_imm_d   = imm_sx;
    end

    if (wb_valid) pending_d[wb_rd] = 1'b0;
    if (kill && out_ctrl_q.rd_write) pending_d[out_rd_q] = 1'b0;
    if (accept && ctrl.rd_write && (rd != '0)) pending_d[rd] = 1'b1;
  end

  // State registers with synchronous reset; register file contents are left untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_ctrl_q  <= '0;
      out_rd_q    <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_imm_q   <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_ctrl_q  <= out_ctrl_d;
      out_rd_q    <= out_rd_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_imm_q   <= out_imm_d;
      pending_q   <= pending_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_alu_op    = out_ctrl_q.alu_op;
  assign out_funct3    = out_ctrl_q.funct3;
  assign out_funct7    = out_ctrl_q.funct7;
  assign out_rd        = out_rd_q;
  assign out_rd_write  = out_ctrl_q.rd_write;
  assign out_rs1_val   = out_rs1_q;
  assign out_rs2_val   = out_rs2_q;
  assign out_imm       = out_imm_q;
  assign out_is_load   = out_ctrl_q.is_load;
  assign out_is_branch = out_ctrl_q.is_branch;
  assign out_illegal   = out_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: operand read, RAW stall, backpressure hold, flush, illegal, reset-in-stall.
// Latency: checks registered outputs 1 ns after the edge, in_ready 2 ns after the edge.
// Backpressure: out_ready driven directly by the stimulus sequence.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_alu_op;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_rd_write;
  logic [31:0] out_rs1_val, out_rs2_val, out_imm;
  logic        out_is_load, out_is_branch, out_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_op(out_alu_op), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_rd_write(out_rd_write),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_is_load(out_is_load), .out_is_branch(out_is_branch), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_rs1", out_rs1_val, 0);
    chk("rst_out_imm", out_imm, 0);
    reset = 1'b0;

    // Preload x1=5, x2=7.
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; step();
    wb_rd = 5'd2; wb_data = 32'd7; step();
    wb_valid = 1'b0;

    // add x3,x1,x2
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100; out_ready = 1'b1;
    #1 chk("add_in_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_rs1", out_rs1_val, 5);
    chk("add_rs2", out_rs2_val, 7);
    chk("add_rd", out_rd, 3);
    chk("add_rd_write", out_rd_write, 1);
    chk("add_op", out_alu_op, 7'h33);
    chk("add_pc", out_pc, 32'h100);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd12; step(); wb_valid = 1'b0;
    chk("add_drained", out_valid, 0);

    // lw x5,0(x1) then add x6,x5,x5
    in_valid = 1'b1; in_instr = 32'h0000A283; in_pc = 32'h104;
    step();
    chk("lw_is_load", out_is_load, 1);
    chk("lw_rd", out_rd, 5);
    chk("lw_rs1", out_rs1_val, 5);
    in_instr = 32'h00528333; in_pc = 32'h108;
    #1 chk("raw_stall_a", in_ready, 0);
    step();
    chk("raw_no_issue_a", out_valid, 0);
    #1 chk("raw_stall_b", in_ready, 0);
    step();
    chk("raw_no_issue_b", out_valid, 0);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h10;
`ifdef DECODE_FWD_EN
    #1 chk("raw_wb_ready", in_ready, 1);
    step(); wb_valid = 1'b0;
`else
    #1 chk("raw_wb_ready", in_ready, 0);
    step(); wb_valid = 1'b0;
    #1 chk("raw_after_wb_ready", in_ready, 1);
    step();
`endif
    in_valid = 1'b0;
    chk("raw_valid", out_valid, 1);
    chk("raw_rd", out_rd, 6);
    chk("raw_rs1", out_rs1_val, 32'h10);
    chk("raw_rs2", out_rs2_val, 32'h10);
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h20; step(); wb_valid = 1'b0;

    // Backpressure hold: addi x9,x1,3 held 3 cycles, then addi x10,x2,-1
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00308493; in_pc = 32'h200;
    step();
    chk("hold_rs2_unused", out_rs2_val, 0);
    in_instr = 32'hFFF10513; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_in_ready", in_ready, 0);
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_pc", out_pc, 32'h200);
      chk("hold_imm", out_imm, 3);
      chk("hold_rd", out_rd, 9);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("next_pc", out_pc, 32'h204);
    chk("next_imm_neg", out_imm, 32'hFFFFFFFF);
    chk("next_rs1", out_rs1_val, 7);
    step();

    // Flush: addi x7,x0,1 killed, then add x8,x7,x7 must not stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100393; in_pc = 32'h300;
    step(); in_valid = 1'b0;
    chk("fl_valid", out_valid, 1);
    chk("fl_imm", out_imm, 1);
    flush = 1'b1;
    #1 chk("fl_in_ready", in_ready, 0);
    step(); flush = 1'b0;
    chk("fl_killed", out_valid, 0);
    in_valid = 1'b1; in_instr = 32'h00738433; in_pc = 32'h304;
    #1 chk("fl_no_stall", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("fl_next_rd", out_rd, 8);
    out_ready = 1'b1;
    step();

    // Illegal instruction
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h400;
    step();
    chk("ill_flag", out_illegal, 1);
    chk("ill_rd_write", out_rd_write, 0);
    in_instr = 32'h01FF85B3; in_pc = 32'h404;
    #1 chk("ill_no_pending", in_ready, 1);
    step();
    chk("ill_next_rd", out_rd, 11);

    // beq x1,x2,+8
    in_instr = 32'h00208463; in_pc = 32'h408;
    step(); in_valid = 1'b0;
    chk("beq_branch", out_is_branch, 1);
    chk("beq_imm", out_imm, 8);
    chk("beq_rd_write", out_rd_write, 0);
    chk("beq_rs2", out_rs2_val, 7);
    step();

    // Reset during a hazard stall: lw x12,0(x1) held, add x13,x12,x12 stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000A603; in_pc = 32'h500;
    step();
    in_instr = 32'h00C606B3; in_pc = 32'h504;
    #1 chk("rs_stall", in_ready, 0);
    step();
    chk("rs_lw_held", out_valid, 1);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("rs_valid", out_valid, 0);
    chk("rs_pc", out_pc, 0);
    #1 chk("rs_pending_clear", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("rs_accept_valid", out_valid, 1);
    chk("rs_accept_rd", out_rd, 13);
    chk("rs_accept_pc", out_pc, 32'h504);
    out_ready = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
